// File: rtl/tpu_pkg.sv
// Shared types and constants for the unified-buffer command sequencer.
package tpu_pkg;

    localparam int unsigned UB_BURST_LEN     = 4;
    localparam int unsigned EXT_DRAIN_CYCLES = 5;

    // Host opcodes; 6 and 7 are reserved and flagged as illegal.
    typedef enum logic [2:0] {
        OpNop    = 3'd0,
        OpDmaIn  = 3'd1,
        OpLoad   = 3'd2,
        OpStore  = 3'd3,
        OpExt    = 3'd4,
        OpClrErr = 3'd5,
        OpIll6   = 3'd6,
        OpIll7   = 3'd7
    } ub_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StDma,
        StLoad,
        StStoreWait,
        StExtPulse,
        StExtDrain,
        StMisc
    } ub_seq_state_t;

    // First active state entered for an accepted opcode.
    function automatic ub_seq_state_t op_state(input ub_op_t op);
        ub_seq_state_t st;
        unique case (op)
            OpDmaIn: st = StDma;
            OpLoad:  st = StLoad;
            OpStore: st = StStoreWait;
            OpExt:   st = StExtPulse;
            default: st = StMisc;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/ub_sequencer.sv
// Unified-buffer command sequencer: expands one host instruction at a time into
// non-overlapping, cycle-exact buffer control pulses.
module ub_sequencer
    import tpu_pkg::*;
#(
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned DMA_W         = 4,
    parameter int unsigned STORE_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic              full_acc1,
    input  logic              full_acc2,
    output logic              fetch_inp,
    output logic [DMA_W-1:0]  dma_address,
    output logic              dma_req,
    output logic              load_input,
    output logic              store,
    output logic              ext,
    output logic [ADDR_W-1:0] addr,
    output logic              out_valid,
    output logic [1:0]        out_idx,
    output logic              done,
    output logic              err_timeout,
    output logic              err_opcode
);

    localparam logic [2:0] DmaLast   = 3'(UB_BURST_LEN - 1);
    localparam logic [2:0] DrainLast = 3'(EXT_DRAIN_CYCLES - 1);
    localparam logic [7:0] TmoLast   = 8'(STORE_TIMEOUT - 1);

    ub_seq_state_t     state_q, state_d;
    logic [2:0]        phase_q, phase_d;
    logic [7:0]        tcnt_q, tcnt_d;
    ub_op_t            op_q, op_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              err_t_q, err_t_d;
    logic              err_o_q, err_o_d;

    logic              ready_q, ready_d;
    logic              fetch_q, fetch_d;
    logic [DMA_W-1:0]  dma_addr_q, dma_addr_d;
    logic              load_q, load_d;
    logic              store_q, store_d;
    logic              ext_q, ext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ov_q, ov_d;
    logic [1:0]        idx_q, idx_d;
    logic              done_q, done_d;
    logic              store_hit;

    // The successful store completes in the very cycle both flags are seen high,
    // so its done pulse cannot be known a cycle early.
    assign store_hit = (state_q == StStoreWait) && full_acc1 && full_acc2;

    // Next-state logic: FSM, counters, latched instruction and sticky errors.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tcnt_d  = tcnt_q;
        op_d    = op_q;
        base_d  = base_q;
        err_t_d = err_t_q;
        err_o_d = err_o_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid && ready_q) begin
                    op_d    = ub_op_t'(instr_op);
                    base_d  = instr_addr;
                    phase_d = 3'd0;
                    tcnt_d  = 8'd0;
                    state_d = op_state(ub_op_t'(instr_op));
                end
            end
            StDma: begin
                if (phase_q == DmaLast) begin
                    state_d = StIdle;
                    phase_d = 3'd0;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            StLoad: state_d = StIdle;
            StStoreWait: begin
                if (full_acc1 && full_acc2) begin
                    state_d = StIdle;
                end else if (tcnt_q == TmoLast) begin
                    state_d = StIdle;
                    err_t_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            StExtPulse: begin
                state_d = StExtDrain;
                phase_d = 3'd0;
            end
            StExtDrain: begin
                if (phase_q == DrainLast) begin
                    state_d = StIdle;
                    phase_d = 3'd0;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            StMisc: begin
                state_d = StIdle;
                if (op_q == OpClrErr) begin
                    err_t_d = 1'b0;
                    err_o_d = 1'b0;
                end else if (op_q == OpIll6 || op_q == OpIll7) begin
                    err_o_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        ready_d    = (state_d == StIdle);
        fetch_d    = (state_d == StDma);
        dma_addr_d = '0;
        if (state_d == StDma) begin
            dma_addr_d = base_d[DMA_W-1:0] + DMA_W'(phase_d);
        end
        load_d  = (state_d == StLoad);
        store_d = (state_d == StStoreWait);
        ext_d   = (state_d == StExtPulse);
        addr_d  = (state_d == StIdle) ? '0 : base_d;
        ov_d    = (state_d == StExtDrain) && (phase_d != 3'd0);
        idx_d   = ov_d ? 2'(phase_d - 3'd1) : 2'd0;
        done_d  = (state_d == StLoad) || (state_d == StMisc) ||
                  ((state_d == StDma) && (phase_d == DmaLast)) ||
                  ((state_d == StExtDrain) && (phase_d == DrainLast)) ||
                  ((state_d == StStoreWait) && (tcnt_d == TmoLast));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            phase_q    <= 3'd0;
            tcnt_q     <= 8'd0;
            op_q       <= OpNop;
            base_q     <= '0;
            err_t_q    <= 1'b0;
            err_o_q    <= 1'b0;
            ready_q    <= 1'b1;
            fetch_q    <= 1'b0;
            dma_addr_q <= '0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            ext_q      <= 1'b0;
            addr_q     <= '0;
            ov_q       <= 1'b0;
            idx_q      <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            tcnt_q     <= tcnt_d;
            op_q       <= op_d;
            base_q     <= base_d;
            err_t_q    <= err_t_d;
            err_o_q    <= err_o_d;
            ready_q    <= ready_d;
            fetch_q    <= fetch_d;
            dma_addr_q <= dma_addr_d;
            load_q     <= load_d;
            store_q    <= store_d;
            ext_q      <= ext_d;
            addr_q     <= addr_d;
            ov_q       <= ov_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
        end
    end

    assign instr_ready = ready_q;
    assign fetch_inp   = fetch_q;
    assign dma_req     = fetch_q;
    assign dma_address = dma_addr_q;
    assign load_input  = load_q;
    assign store       = store_q;
    assign ext         = ext_q;
    assign addr        = addr_q;
    assign out_valid   = ov_q;
    assign out_idx     = idx_q;
    assign done        = done_q | store_hit;
    assign err_timeout = err_t_q;
    assign err_opcode  = err_o_q;

endmodule

// File: tb/tb_ub_sequencer.sv
// Cycle-by-cycle directed bench for ub_sequencer (STORE_TIMEOUT = 8).
module tb_ub_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [4:0] instr_addr;
    logic       full_acc1, full_acc2;
    logic       fetch_inp;
    logic [3:0] dma_address;
    logic       dma_req, load_input, store, ext;
    logic [4:0] addr;
    logic       out_valid;
    logic [1:0] out_idx;
    logic       done, err_timeout, err_opcode;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    ub_sequencer #(.ADDR_W(5), .DMA_W(4), .STORE_TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_addr  (instr_addr),
        .full_acc1   (full_acc1),
        .full_acc2   (full_acc2),
        .fetch_inp   (fetch_inp),
        .dma_address (dma_address),
        .dma_req     (dma_req),
        .load_input  (load_input),
        .store       (store),
        .ext         (ext),
        .addr        (addr),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .done        (done),
        .err_timeout (err_timeout),
        .err_opcode  (err_opcode)
    );

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [4:0]  ad;
        logic        f1;
        logic        f2;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];

    // {ready, fetch, dma_req, dma_address, load, store, ext, addr, out_valid, out_idx, done,
    //  err_timeout, err_opcode}
    function automatic logic [20:0] ex(input logic rdy, input logic fet, input logic [3:0] da,
                                       input logic ld, input logic st, input logic xt,
                                       input logic [4:0] ad, input logic ov,
                                       input logic [1:0] oi, input logic dn,
                                       input logic et, input logic eo);
        return {rdy, fet, fet, da, ld, st, xt, ad, ov, oi, dn, et, eo};
    endfunction

    function automatic logic [20:0] obs();
        return {instr_ready, fetch_inp, dma_req, dma_address, load_input, store, ext, addr,
                out_valid, out_idx, done, err_timeout, err_opcode};
    endfunction

    function automatic logic [20:0] idle(input logic et, input logic eo);
        return ex(1, 0, 4'd0, 0, 0, 0, 5'd0, 0, 2'd0, 0, et, eo);
    endfunction

    task automatic add(input logic v, input logic [2:0] op, input logic [4:0] ad,
                       input logic f1, input logic f2, input logic [20:0] e);
        vecs.push_back('{v, op, ad, f1, f2, e});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s: got %h, expected %h", name, act, req);
        else n_pass++;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] ad,
                         input logic f1, input logic f2);
        instr_valid = v;
        instr_op    = op;
        instr_addr  = ad;
        full_acc1   = f1;
        full_acc2   = f2;
    endtask

    initial begin
        int n_cyc;
        int n_ov;
        bit seen;

        reset = 1'b1;
        drive(0, 3'd0, 5'd0, 0, 0);

        // DMA_IN base 14: addresses wrap 14,15,0,1
        add(1, 3'd1, 5'd14, 0, 0, idle(0, 0));
        add(0, 3'd0, 5'd0, 0, 0, ex(0, 1, 4'd14, 0, 0, 0, 5'd14, 0, 2'd0, 0, 0, 0));
        add(0, 3'd0, 5'd0, 0, 0, ex(0, 1, 4'd15, 0, 0, 0, 5'd14, 0, 2'd0, 0, 0, 0));
        add(0, 3'd0, 5'd0, 0, 0, ex(0, 1, 4'd0,  0, 0, 0, 5'd14, 0, 2'd0, 0, 0, 0));
        add(0, 3'd0, 5'd0, 0, 0, ex(0, 1, 4'd1,  0, 0, 0, 5'd14, 0, 2'd0, 1, 0, 0));
        // LOAD addr 3
        add(1, 3'd2, 5'd3, 0, 0, idle(0, 0));
        add(0, 3'd0, 5'd0, 0, 0, ex(0, 0, 4'd0, 1, 0, 0, 5'd3, 0, 2'd0, 1, 0, 0));
        // STORE addr 4, both flags at A+6 (one flag alone at A+5 must not exit)
        add(1, 3'd3, 5'd4, 0, 0, idle(0, 0));
        for (int i = 0; i < 4; i++)
            add(0, 3'd0, 5'd0, 0, 0, ex(0, 0, 4'd0, 0, 1, 0, 5'd4, 0, 2'd0, 0, 0, 0));
        add(0, 3'd0, 5'd0, 1, 0, ex(0, 0, 4'd0, 0, 1, 0, 5'd4, 0, 2'd0, 0, 0, 0));
        add(0, 3'd0, 5'd0, 1, 1, ex(0, 0, 4'd0, 0, 1, 0, 5'd4, 0, 2'd0, 1, 0, 0));
        // STORE addr 9, flags never high: 8 store cycles then timeout
        add(1, 3'd3, 5'd9, 0, 0, idle(0, 0));
        for (int i = 0; i < 7; i++)
            add(0, 3'd0, 5'd0, 0, 0, ex(0, 0, 4'd0, 0, 1, 0, 5'd9, 0, 2'd0, 0, 0, 0));
        add(0, 3'd0, 5'd0, 0, 0, ex(0, 0, 4'd0, 0, 1, 0, 5'd9, 0, 2'd0, 1, 0, 0));
        // Illegal opcode 6
        add(1, 3'd6, 5'd2, 0, 0, idle(1, 0));
        add(0, 3'd0, 5'd0, 0, 0, ex(0, 0, 4'd0, 0, 0, 0, 5'd2, 0, 2'd0, 1, 1, 0));
        // CLRERR: flags clear at A+2
        add(1, 3'd5, 5'd0, 0, 0, idle(1, 1));
        add(0, 3'd0, 5'd0, 0, 0, ex(0, 0, 4'd0, 0, 0, 0, 5'd0, 0, 2'd0, 1, 1, 1));
        // EXT addr 0 with op 7 held valid while busy
        add(1, 3'd4, 5'd0, 0, 0, idle(0, 0));
        add(0, 3'd0, 5'd0, 0, 0, ex(0, 0, 4'd0, 0, 0, 1, 5'd0, 0, 2'd0, 0, 0, 0));
        add(1, 3'd7, 5'd5, 0, 0, ex(0, 0, 4'd0, 0, 0, 0, 5'd0, 0, 2'd0, 0, 0, 0));
        add(1, 3'd7, 5'd5, 0, 0, ex(0, 0, 4'd0, 0, 0, 0, 5'd0, 1, 2'd0, 0, 0, 0));
        add(1, 3'd7, 5'd5, 0, 0, ex(0, 0, 4'd0, 0, 0, 0, 5'd0, 1, 2'd1, 0, 0, 0));
        add(1, 3'd7, 5'd5, 0, 0, ex(0, 0, 4'd0, 0, 0, 0, 5'd0, 1, 2'd2, 0, 0, 0));
        add(1, 3'd7, 5'd5, 0, 0, ex(0, 0, 4'd0, 0, 0, 0, 5'd0, 1, 2'd3, 1, 0, 0));
        add(1, 3'd7, 5'd5, 0, 0, idle(0, 0));
        add(0, 3'd0, 5'd0, 0, 0, ex(0, 0, 4'd0, 0, 0, 0, 5'd5, 0, 2'd0, 1, 0, 0));
        add(0, 3'd0, 5'd0, 0, 0, idle(0, 1));

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_state", 32'(obs()), 32'(idle(0, 0)));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i].v, vecs[i].op, vecs[i].ad, vecs[i].f1, vecs[i].f2);
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
        end

        // Reset during DMA cycle 2 (err_opcode is still set from op 7)
        @(posedge clk);
        #1 drive(1, 3'd1, 5'd6, 0, 0);
        @(posedge clk);
        #1 drive(0, 3'd0, 5'd0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("dma_cycle2", 32'(obs()), 32'(ex(0, 1, 4'd7, 0, 0, 0, 5'd6, 0, 2'd0, 0, 0, 1)));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("after_reset", 32'(obs()), 32'(idle(0, 0)));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("no_partial_dma%0d", i), 32'(obs()), 32'(idle(0, 0)));
        end

        // EXT latency measured with a bounded wait for done
        @(posedge clk);
        #1 drive(1, 3'd4, 5'd20, 0, 0);
        @(posedge clk);
        #1 drive(0, 3'd0, 5'd0, 0, 0);
        n_cyc = 0;
        n_ov  = 0;
        seen  = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            n_cyc++;
            if (out_valid) n_ov++;
            if (done) seen = 1;
        end
        chk("ext_done_seen", 32'(seen), 32'd1);
        chk("ext_done_latency", 32'(n_cyc), 32'd6);
        chk("ext_valid_count", 32'(n_ov), 32'd4);
        @(negedge clk);
        chk("ext_ready_back", 32'(instr_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ub_sequencer.md
# ub_sequencer

Command sequencer for the unified buffer. Accepts one host instruction at a time over a valid/ready handshake and expands it into cycle-exact control pulses on the buffer's control inputs: `fetch_inp`/`dma_address`, `load_input`, `store`, `ext` and `addr`. It sits between the host-facing instruction decoder and the unified buffer. It guarantees that buffer operations never overlap, that stores wait for both accumulators, and that output readout is framed with a valid strobe.

## Interface
Parameters:
- `ADDR_W`, default 5: buffer address width (`addr`, `instr_addr`).
- `DMA_W`, default 4: DMA address width; DMA addresses wrap mod 2^DMA_W.
- `STORE_TIMEOUT`, default 255: maximum STORE_WAIT cycles before abort (8-bit counter).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  sequencer can accept; high only in IDLE.
- `instr_op`  in  3  opcode.
- `instr_addr`  in  ADDR_W  base address.
- `full_acc1`, `full_acc2`  in  1 each  accumulator full flags.
- `fetch_inp`  out  1  buffer write-from-host strobe.
- `dma_address`  out  DMA_W  buffer host-write address.
- `dma_req`  out  1  host must drive the next byte on `ui_in` this cycle.
- `load_input`  out  1  buffer read-to-setup strobe.
- `store`  out  1  buffer accumulator-store request.
- `ext`  out  1  buffer readout start pulse.
- `addr`  out  ADDR_W  buffer address, held for the whole operation.
- `out_valid`  out  1  buffer `final_out` carries data this cycle.
- `out_idx`  out  2  element index of the current `final_out`.
- `done`  out  1  one-cycle pulse in the last active cycle of every instruction.
- `err_timeout`, `err_opcode`  out  1 each  sticky error flags.

## Operation
- Handshake: an instruction is accepted on a rising edge when `instr_valid && instr_ready`. Opcode and address are latched at acceptance.
- Opcodes:
  - NOP=0
  - DMA_IN=1: 4 bytes to `dma_address` = base[DMA_W-1:0]+k, k=0..3, wrapping.
  - LOAD=2: single `load_input` pulse.
  - STORE=3: hold `store` until both full flags are high.
  - EXT=4: readout of 4 elements.
  - CLRERR=5: clears both sticky error flags.
  - 6 and 7 are illegal: set `err_opcode`, otherwise complete as NOP.
- States:
  - IDLE
  - DMA: 4 cycles; a 2-bit counter k drives `dma_address`.
  - LOAD: 1 cycle.
  - STORE_WAIT
  - EXT_PULSE: 1 cycle.
  - EXT_DRAIN: 5 cycles.
  - MISC: 1 cycle; covers NOP, CLRERR and illegal opcodes.
- Transitions:
  - IDLE to the op state on accept.
  - DMA, LOAD, MISC to IDLE after their cycles.
  - STORE_WAIT to IDLE on full (both flags) or timeout.
  - EXT_PULSE to EXT_DRAIN; EXT_DRAIN to IDLE.
- STORE:
  - `store` is high every cycle in STORE_WAIT.
  - Exit occurs on the edge where `full_acc1 && full_acc2` is sampled high. That is the same edge on which the buffer writes, so exactly one write happens.
  - If the wait count reaches STORE_TIMEOUT without both flags high: set `err_timeout`, pulse `done`, return to IDLE, and make no write.
- `addr` = latched base in every non-IDLE state; 0 in IDLE.
- All control outputs are registered. Reset value of every output is 0, except `instr_ready`, which is 1 in the cycle after reset.
- Reset mid-operation: next cycle all strobes are 0, state is IDLE, counters and error flags are 0. No partial DMA continues.
- `instr_valid` while busy is ignored (not accepted) and causes no error.

## Timing
Cycle A is the accept cycle.
- DMA_IN:
  - `fetch_inp` = `dma_req` = 1 in A+1..A+4, with `dma_address` base..base+3.
  - `done` at A+4; `instr_ready` at A+5.
- LOAD:
  - `load_input` = 1 at A+1, with `done`.
  - Buffer `out_ub_*` are valid from A+2; `instr_ready` at A+2.
- STORE:
  - `store` from A+1 through cycle F, where F is the first cycle with both full flags high; `done` at F; ready at F+1.
  - Timeout case: `store` high for STORE_TIMEOUT cycles, then `done`.
- EXT:
  - `ext` = 1 at A+1 only.
  - `out_valid` = 1 at A+3..A+6, with `out_idx` 0..3 (`final_out` = mem[base+idx]).
  - `done` at A+6; ready at A+7. This guarantees the buffer's readout FSM has returned to IDLE before the next `ext`.
- NOP, CLRERR, illegal: `done` at A+1; error flags update visible at A+2.
- Back-to-back throughput: one instruction per (op length + 1) cycles. No instruction overlaps another.

## Structure
- Shared package `tpu_pkg`: `ub_op_t` opcode enum (values above), `ub_seq_state_t` enum, constants UB_BURST_LEN=4 and EXT_DRAIN_CYCLES=5.
- Single flat module, no sub-module. Contents:
  - state register
  - 3-bit phase counter (DMA k, drain count)
  - 8-bit timeout counter
  - latched opcode and address
  - registered outputs

## Test plan
- Reset then DMA_IN base=14 → `fetch_inp` 4 cycles with `dma_address` 14,15,0,1; `done` at A+4; `instr_ready` back at A+5.
- STORE addr=4, full flags rise at A+6 → `store` high A+1..A+6; exactly one buffer write of acc values to 4..7; `err_timeout`=0.
- STORE with flags never high, STORE_TIMEOUT=8 → `store` deasserts after 8 cycles; `err_timeout`=1 persists until CLRERR, which clears it at A+2.
- DMA 4 bytes to 0..3, then EXT addr=0 → `out_valid` A+3..A+6; `final_out` equals the bytes in order; `out_idx` 0..3.
- `instr_valid` held high with LOAD, EXT, op 7 queued → each accepted only when `instr_ready`; op 7 sets `err_opcode`; no strobes overlap.
- Reset asserted during DMA cycle 2 → all outputs 0 the next cycle; IDLE with `instr_ready`=1 after reset deasserts.
